// File: rtl/hex_scan_display.sv
// Multiplexed NDIGITS-digit hex driver for a shared active-low 7-segment bus.
// Optional blink support is compiled in with `define HEX_SCAN_DISPLAY_BLINK_EN.
module hex_scan_display #(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 1024
`ifdef HEX_SCAN_DISPLAY_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   blank_lz,
`ifdef HEX_SCAN_DISPLAY_BLINK_EN
  input  logic                   blink,
`endif
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     dig_sel,
  output logic                   frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

  logic [PW-1:0]          prescaler;
  logic [IW-1:0]          index;
  logic [4*NDIGITS-1:0]   pending;
  logic [4*NDIGITS-1:0]   active;

  logic                   tick;
  logic                   frame;
  logic [IW-1:0]          index_n;
  logic [4*NDIGITS-1:0]   active_n;
  logic [NDIGITS:0]       lz;
  logic [3:0]             digit;
  logic                   hide;
  logic                   mask;
  logic [NDIGITS-1:0]     sel_n;
  logic [6:0]             seg_n;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

`ifdef HEX_SCAN_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] fcnt, fcnt_n;
  logic          phase_off, phase_off_n;

  always_comb begin
    fcnt_n      = fcnt;
    phase_off_n = phase_off;
    if (!blink) begin
      fcnt_n      = '0;
      phase_off_n = 1'b0;
    end else if (frame) begin
      if (fcnt == BW'(BLINK_FRAMES - 1)) begin
        fcnt_n      = '0;
        phase_off_n = ~phase_off;
      end else begin
        fcnt_n = fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt      <= '0;
      phase_off <= 1'b0;
    end else begin
      fcnt      <= fcnt_n;
      phase_off <= phase_off_n;
    end
  end

  // The phase seen by the new frame is applied at its boundary tick.
  assign mask = blink & phase_off_n;
`else
  assign mask = 1'b0;
`endif

  always_comb begin
    tick    = (prescaler == PW'(SCAN_DIV - 1));
    frame   = tick && (index == LAST);
    index_n = (index == LAST) ? '0 : index + 1'b1;
    // Outputs at the boundary already show the incoming value, so a frame is never mixed.
    active_n = frame ? (load ? value : pending) : active;

    lz[NDIGITS] = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--)
      lz[i] = lz[i+1] && (active_n[4*i +: 4] == 4'h0);

    digit = 4'h0;
    hide  = 1'b0;
    sel_n = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (IW'(i) == index_n) begin
        digit    = active_n[4*i +: 4];
        hide     = blank_lz && (i != 0) && lz[i];
        sel_n[i] = 1'b1;
      end
    end

    seg_n = (hide || mask) ? 7'h7F : seg7(digit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler  <= '0;
      index      <= '0;
      pending    <= '0;
      active     <= '0;
      seg        <= 7'h7F;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      if (load)
        pending <= value;
      active     <= active_n;
      frame_done <= frame;
      if (tick) begin
        index   <= index_n;
        seg     <= seg_n;
        dig_sel <= sel_n;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display (NDIGITS=4, SCAN_DIV=4); blink scenario
// is included when HEX_SCAN_DISPLAY_BLINK_EN is defined.
module tb_hex_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
`ifdef HEX_SCAN_DISPLAY_BLINK_EN
  logic        blink;
`endif
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int t = 0;

  // expected {dig_sel, seg, frame_done} per scan tick
  logic [11:0] q[$];
  logic [3:0]  prev_sel = 4'h0;

  always #5 clk = ~clk;

  hex_scan_display #(
    .NDIGITS(4),
    .SCAN_DIV(4)
`ifdef HEX_SCAN_DISPLAY_BLINK_EN
    ,
    .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .value(value),
    .blank_lz(blank_lz),
`ifdef HEX_SCAN_DISPLAY_BLINK_EN
    .blink(blink),
`endif
    .seg(seg),
    .dig_sel(dig_sel),
    .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic [6:0] s, input logic f);
    q.push_back({d, s, f});
  endtask

  // Display order within a frame: digit1, digit2, digit3, then digit0 with frame_done.
  task automatic push_frame(input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [6:0] s0);
    push(4'b0010, s1, 1'b0);
    push(4'b0100, s2, 1'b0);
    push(4'b1000, s3, 1'b0);
    push(4'b0001, s0, 1'b1);
  endtask

  task automatic go_to(input int n);
    while (t < n) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic check_idle_start();
    for (int k = 1; k <= 3; k++) begin
      go_to(k);
      chk("idle_seg", {25'd0, seg}, 32'h7F);
      chk("idle_sel", {28'd0, dig_sel}, 32'h0);
    end
  endtask

  // Monitor: every new digit selection is one DUT output event.
  always @(negedge clk) begin
    logic [11:0] exp;
    if (dig_sel != prev_sel && dig_sel != 4'h0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: sel=%b seg=%h fd=%b with empty queue at %0t",
                 dig_sel, seg, frame_done, $time);
      end else begin
        exp = q.pop_front();
        if ({dig_sel, seg, frame_done} !== exp) begin
          errors++;
          $display("FAIL scan: got sel=%b seg=%h fd=%b expected sel=%b seg=%h fd=%b at %0t",
                   dig_sel, seg, frame_done, exp[11:8], exp[7:1], exp[0], $time);
        end
      end
    end
    prev_sel = dig_sel;
  end

  initial begin
    reset = 1'b1; load = 1'b0; value = 16'h0; blank_lz = 1'b0;
`ifdef HEX_SCAN_DISPLAY_BLINK_EN
    blink = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_sel", {28'd0, dig_sel}, 32'h0);
    chk("rst_fd", {31'd0, frame_done}, 32'h0);
    reset = 1'b0;
    t = 0;

    // reset release, idle scan of zero
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
    check_idle_start();

    // load 1A3F mid-frame: shows only from the next boundary
    push_frame(7'h40, 7'h40, 7'h40, 7'h0E);
    go_to(17); value = 16'h1A3F; load = 1'b1;
    go_to(18); load = 1'b0;
    push_frame(7'h30, 7'h08, 7'h79, 7'h0E);

    // leading-zero blanking of 0050
    push_frame(7'h30, 7'h08, 7'h79, 7'h40);
    go_to(49); value = 16'h0050; load = 1'b1; blank_lz = 1'b1;
    go_to(50); load = 1'b0;
    push_frame(7'h12, 7'h7F, 7'h7F, 7'h40);

    // 1111 mid-frame, 2222 on the boundary cycle: 2222 wins
    go_to(81); blank_lz = 1'b0;
    push_frame(7'h12, 7'h40, 7'h40, 7'h24);
    go_to(89); value = 16'h1111; load = 1'b1;
    go_to(90); load = 1'b0;
    go_to(95); value = 16'h2222; load = 1'b1;
    go_to(96); load = 1'b0;
    push_frame(7'h24, 7'h24, 7'h24, 7'h24);

    // FFFF active, then reset mid-frame
    push_frame(7'h24, 7'h24, 7'h24, 7'h0E);
    go_to(113); value = 16'hFFFF; load = 1'b1;
    go_to(114); load = 1'b0;
    push(4'b0010, 7'h0E, 1'b0);
    go_to(134);
    #2 reset = 1'b1;
    #1;
    chk("midrst_seg", {25'd0, seg}, 32'h7F);
    chk("midrst_sel", {28'd0, dig_sel}, 32'h0);
    chk("midrst_fd", {31'd0, frame_done}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    t = 0;
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
    check_idle_start();

`ifdef HEX_SCAN_DISPLAY_BLINK_EN
    go_to(33); blink = 1'b1;
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
    push_frame(7'h40, 7'h40, 7'h40, 7'h7F);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h40);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
`endif

    for (int k = 0; k < 400 && q.size() != 0; k++)
      @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
- Parametrised multi-digit hex display driver for the board's 7-segment outputs.
- Holds an NDIGITS-digit hex value in a pending/active register pair and time-multiplexes it onto one shared segment bus with a one-hot digit select.
- Optional leading-zero blanking.
- Value updates are frame-synchronous, so a partly old, partly new number is never shown.
- Sits between the Collatz datapath (result/step count) and the board display pins.

Parameters:
- NDIGITS, 4, number of hex digits displayed (1..8).
- SCAN_DIV, 1024, clk cycles each digit is driven (>=2); prescaler width = $clog2(SCAN_DIV).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  capture value into pending register this cycle.
- value  input  4*NDIGITS  hex value; digit i = value[4i+3:4i], digit 0 least significant.
- blank_lz  input  1  1 = blank leading zero digits (sampled live each scan tick).
- seg  output  7  active-low segments {g,f,e,d,c,b,a}; 0 = lit.
- dig_sel  output  NDIGITS  one-hot digit enable, active-high; bit i drives digit i.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset (asynchronous, immediate):
  - pending = 0, active = 0, prescaler = 0, index = 0.
  - seg = 7'b1111111, dig_sel = 0, frame_done = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = (prescaler == SCAN_DIV-1).
  - First tick is the SCAN_DIV-th rising edge after reset release.
- On tick:
  - index advances i -> i+1, wrapping NDIGITS-1 -> 0.
  - seg/dig_sel are registered from the digit at the new index; outputs change exactly on tick edges.
  - After the first tick, digit 1 is driven; digit 0 is driven once per frame, after the wrap.
  - Display latency from a tick to output change is 0 extra cycles.
- Frame boundary = tick where index wraps NDIGITS-1 -> 0:
  - frame_done = 1 for that cycle only.
  - active <= pending.
  - For NDIGITS = 1, every tick is a frame boundary.
- Load:
  - pending <= value on any edge with load = 1.
  - If load coincides with a frame boundary, active <= value directly (the new value wins).
  - Multiple loads within one frame: the last one wins.
  - active never changes mid-frame.
- Segment encoding (active-low, {g..a}), hex 0..F:
  - 0..7: 40, 79, 24, 30, 19, 12, 02, 78.
  - 8..F: 00, 10, 08, 03, 46, 21, 06, 0E.
- Leading-zero blanking:
  - Digit i > 0 is blanked (seg = 7F, dig_sel bit still asserted) when blank_lz = 1 and active digits i..NDIGITS-1 are all 0.
  - Digit 0 is never blanked; value 0 shows a single "0".
- Reset asserted mid-frame: all state clears at once; pending and active values are lost.
- Width rule: index width = max(1, $clog2(NDIGITS)); index values >= NDIGITS are unreachable.

Optional Feature:
- HEX_SCAN_DISPLAY_BLINK_EN defined:
  - Adds input blink (1 bit) and parameter BLINK_FRAMES (default 32).
  - A frame counter toggles a blink phase every BLINK_FRAMES frame boundaries.
  - While blink = 1 and phase = off: seg = 7F; dig_sel and scanning continue normally.
  - Phase and counter reset to on/0. When blink = 0, phase is held at on and the counter at 0.
- Undefined: no blink port or counter; behaviour exactly as above.

Test Plan:
All scenarios use NDIGITS=4, SCAN_DIV=4.
1. Reset release, no load, blank_lz=0:
   - seg=7F and dig_sel=0 for cycles 1-3.
   - Cycle 4: dig_sel=0010, seg=40.
   - Cycle 16: dig_sel=0001, frame_done pulses.
2. load value=16'h1A3F at cycle 2:
   - Still shows 0 until the first frame boundary (cycle 16).
   - Next frame: digit0=0E, digit1=30, digit2=08, digit3=79.
3. active=16'h0050, blank_lz=1:
   - digit3=7F, digit2=7F, digit1=12, digit0=40; all dig_sel bits still scanned.
4. Load 16'h1111 mid-frame, then 16'h2222 on the frame-boundary cycle:
   - Next frame displays all digits as 24; 1111 is never displayed.
5. Assert reset mid-frame with active=16'hFFFF:
   - Same cycle: seg=7F, dig_sel=0, frame_done=0.
   - After release: scan restarts as in scenario 1, showing 0.
6. With HEX_SCAN_DISPLAY_BLINK_EN, BLINK_FRAMES=2, blink=1:
   - seg lit for 2 frames, 7F for 2 frames, repeating.
   - dig_sel scan is unchanged throughout.
